// File: rtl/ssd_scan_decoder_if.sv
// Snoop bus between a multiplexed seven-segment scanner (master) and the scan decoder (slave).
// Stale exists only when SSD_SCAN_TIMEOUT_EN is defined.
interface ssd_scan_decoder_if;
    logic [3:0]  An;
    logic [7:0]  Cath;
    logic [15:0] Hex;
    logic [3:0]  Dp_on;
    logic [3:0]  Valid;
    logic        New_pulse;
    logic        Frame_pulse;
    logic        Err;
`ifdef SSD_SCAN_TIMEOUT_EN
    logic        Stale;

    modport master (
        output An, Cath,
        input  Hex, Dp_on, Valid, New_pulse, Frame_pulse, Err, Stale
    );

    modport slave (
        input  An, Cath,
        output Hex, Dp_on, Valid, New_pulse, Frame_pulse, Err, Stale
    );
`else
    modport master (
        output An, Cath,
        input  Hex, Dp_on, Valid, New_pulse, Frame_pulse, Err
    );

    modport slave (
        input  An, Cath,
        output Hex, Dp_on, Valid, New_pulse, Frame_pulse, Err
    );
`endif
endinterface

// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan snooper: 2-flop sync, per-digit settle filter, segment-to-hex decode; no backpressure.
// Outputs update SETTLE+3 cycles after a digit pattern appears; SSD_SCAN_TIMEOUT_EN adds the idle-scan timeout and Stale.
module ssd_scan_decoder #(
    parameter int unsigned SETTLE = 16,
    parameter int unsigned TO_W   = 24
) (
    input  logic              Clk,
    input  logic              Reset_n,
    ssd_scan_decoder_if.slave bus
);

    if (SETTLE < 1 || SETTLE > 65535 || TO_W < 1) begin : g_param_err
        $error("ssd_scan_decoder: SETTLE must be 1..65535 and TO_W >= 1");
    end

    localparam logic [15:0] SETTLE_L  = 16'(SETTLE);
    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE - 1);

    // Returns {good, nibble}; Cath[7:1] = abcdefg, active-low.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: return {1'b1, 4'h0};
            7'b1001111: return {1'b1, 4'h1};
            7'b0010010: return {1'b1, 4'h2};
            7'b0000110: return {1'b1, 4'h3};
            7'b1001100: return {1'b1, 4'h4};
            7'b0100100: return {1'b1, 4'h5};
            7'b0100000: return {1'b1, 4'h6};
            7'b0001111: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0000100: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b1100000: return {1'b1, 4'hB};
            7'b0110001: return {1'b1, 4'hC};
            7'b1000010: return {1'b1, 4'hD};
            7'b0110000: return {1'b1, 4'hE};
            7'b0111000: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    logic [3:0]  an_m_q, an_s_q;
    logic [7:0]  cath_m_q, cath_s_q;
    logic [11:0] prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] hex_q, hex_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  mask_q, mask_d;
    logic        new_q, new_d;
    logic        frame_q, frame_d;
    logic        err_q, err_d;

    logic        legal;
    logic [1:0]  sel;
    logic        same;
    logic        fire;
    logic        good;
    logic [3:0]  nib;
    logic        dp_new;

`ifdef SSD_SCAN_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_d;
    logic            stale_q, stale_d;
`endif

    always_comb begin
        legal = 1'b1;
        sel   = 2'd0;
        case (an_s_q)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        same        = ({an_s_q, cath_s_q} == prev_q);
        {good, nib} = seg_decode(cath_s_q[7:1]);
        dp_new      = ~cath_s_q[0];

        cnt_d = cnt_q;
        if (!legal || !same) begin
            cnt_d = '0;
        end else if (cnt_q != SETTLE_L) begin
            cnt_d = cnt_q + 16'd1;
        end
        // Fires only on the step into saturation, so one dwell captures once.
        fire = legal && same && (cnt_q == SETTLE_M1);

        hex_d   = hex_q;
        dp_d    = dp_q;
        valid_d = valid_q;
        mask_d  = mask_q;
        err_d   = err_q;
        new_d   = 1'b0;
        frame_d = 1'b0;

        if (fire) begin
            mask_d[sel] = 1'b1;
            if (good) begin
                new_d = (hex_q[{sel, 2'b00} +: 4] != nib) || (dp_q[sel] != dp_new) || !valid_q[sel];
                hex_d[{sel, 2'b00} +: 4] = nib;
                dp_d[sel]    = dp_new;
                valid_d[sel] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

`ifdef SSD_SCAN_TIMEOUT_EN
        to_d    = to_q;
        stale_d = stale_q;
        if (legal) begin
            to_d = '0;
        end else if (!(&to_q)) begin
            to_d = to_q + TO_W'(1);
        end
        if (&to_q) begin
            valid_d = '0;
            mask_d  = '0;
            stale_d = 1'b1;
        end
        if (fire && good) begin
            stale_d = 1'b0;
        end
`endif

        if (mask_d == 4'hF) begin
            frame_d = 1'b1;
            mask_d  = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            an_m_q   <= 4'hF;
            an_s_q   <= 4'hF;
            cath_m_q <= 8'hFF;
            cath_s_q <= 8'hFF;
            prev_q   <= 12'hFFF;
            cnt_q    <= '0;
            hex_q    <= '0;
            dp_q     <= '0;
            valid_q  <= '0;
            mask_q   <= '0;
            new_q    <= 1'b0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SSD_SCAN_TIMEOUT_EN
            to_q     <= '0;
            stale_q  <= 1'b0;
`endif
        end else begin
            an_m_q   <= bus.An;
            an_s_q   <= an_m_q;
            cath_m_q <= bus.Cath;
            cath_s_q <= cath_m_q;
            prev_q   <= {an_s_q, cath_s_q};
            cnt_q    <= cnt_d;
            hex_q    <= hex_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            mask_q   <= mask_d;
            new_q    <= new_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
`ifdef SSD_SCAN_TIMEOUT_EN
            to_q     <= to_d;
            stale_q  <= stale_d;
`endif
        end
    end

    assign bus.Hex         = hex_q;
    assign bus.Dp_on       = dp_q;
    assign bus.Valid       = valid_q;
    assign bus.New_pulse   = new_q;
    assign bus.Frame_pulse = frame_q;
    assign bus.Err         = err_q;
`ifdef SSD_SCAN_TIMEOUT_EN
    assign bus.Stale       = stale_q;
`endif

endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver.
- Snoops the active-low anode and cathode lines that the display scanner drives, waits for each digit's pattern to settle, and decodes the segment pattern back to a 4-bit hex value per digit.
- Used for on-board loopback self-test and for bench checking of top-level display output, without relying on visual inspection.

Parameters:
- SETTLE, 16, cycles a single-anode/cathode pattern must be stable before it is captured (1..65535).
- TO_W, 24, width of the scan-timeout counter (used only with the optional feature).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- An  input  4  anode lines, active-low; An[3] = leftmost digit.
- Cath  input  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.
- Hex  output  16  decoded digits {D3,D2,D1,D0}, 4 bits each.
- Dp_on  output  4  per-digit decimal point lit (Dp was 0 at capture).
- Valid  output  4  per-digit: at least one good capture since reset.
- New_pulse  output  1  one-cycle pulse when any captured value differs from its stored value.
- Frame_pulse  output  1  one-cycle pulse when all four digits have been captured since the previous Frame_pulse.
- Err  output  1  sticky: an undecodable segment pattern was captured.

Behaviour:
- Reset (Reset_n=0 at a clock edge): Hex=0, Dp_on=0, Valid=0, New_pulse=0, Frame_pulse=0, Err=0, settle counter=0, frame mask=0.
- Inputs pass through a 2-flop synchronizer before any use. Latency from an input change to the synchronized value is 2 cycles.
- Digit select: the synchronized An is legal only when exactly one bit is 0. All-ones, or two or more zeros, is idle. Idle clears the settle counter and captures nothing.
- Settle: the counter clears whenever the synchronized {An,Cath} differs from its value in the previous cycle. Otherwise it increments and saturates at SETTLE.
- Capture fires on the single cycle the counter reaches SETTLE with a legal An. The same dwell does not capture again until the pattern changes.
- Decode uses Cath[7:1] = abcdefg, active-low:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F
- Good capture into digit k:
  - Hex nibble k and Dp_on[k] are updated the cycle after the capture fires.
  - Valid[k] is set.
  - Frame mask bit k is set.
  - New_pulse is asserted in the same cycle as the update if the nibble or Dp differs from the stored value, or if Valid[k] was 0.
- Bad capture (pattern not in the table, including all segments off):
  - Err is set; it stays set until reset.
  - Hex, Dp_on and Valid are unchanged, and no New_pulse is generated.
  - The frame mask bit is still set, because the digit was scanned.
- Frame: when the frame mask becomes 1111, Frame_pulse is asserted for 1 cycle and the mask clears in the same cycle. Digit order does not matter.
- Reset asserted mid-dwell or mid-frame: all state returns to reset values. A capture in progress is discarded.
- Output pulses never last longer than 1 cycle. New_pulse and Frame_pulse may coincide.

Optional Feature:
- Macro: SSD_SCAN_TIMEOUT_EN.
- When defined:
  - A TO_W-bit counter increments every cycle the synchronized An is idle and clears on any legal An.
  - When it saturates at all ones, Valid is cleared to 0000 and the frame mask is cleared.
  - Output Stale (1 bit) goes to 1 and clears on the next good capture.
- When not defined:
  - No timeout counter exists and the Stale port does not exist.
  - Valid is only ever cleared by reset.

Test Plan:
- Reset then An=1110, Cath=00001101 held for 30 cycles with SETTLE=16 -> Hex[3:0]=3, Dp_on[0]=0, Valid=0001, exactly one New_pulse, Err=0.
- Drive An=0111/1011/1101/1110 with A, b, C, d (Dp=1) at 20 cycles each -> Hex=16'hABCD, Valid=1111, one Frame_pulse after the fourth capture, 4 New_pulses.
- Repeat the same frame a second time -> Hex unchanged, no New_pulse, one Frame_pulse.
- Hold An=1110 and toggle Cath between 0 and 8 every 5 cycles (shorter than SETTLE) -> no capture, no pulses, Hex unchanged.
- An=1110, Cath=11111111 (blank) held 30 cycles -> Err=1, Hex[3:0] unchanged. Then An=1100 with a valid pattern -> ignored, no capture.
- With SSD_SCAN_TIMEOUT_EN and TO_W=4: after a full frame, hold An=1111 for 16 cycles -> Valid=0000, Stale=1. Next good capture -> Stale=0.
